// File: rtl/mult_rem_seq.sv
// mult_rem_seq: sequential shift-add multiplier with an optional addend.
// product = quotient * divisor (+ remainder), unsigned or two's complement.
// Define MULT_REM_SEQ_REM_EN to enable the remainder addend; when it is
// undefined the remainder port is ignored and product = quotient * divisor.
module mult_rem_seq #(
    parameter int unsigned width = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               tc_mode,
    input  logic [width-1:0]   quotient,
    input  logic [width-1:0]   divisor,
    input  logic [width-1:0]   remainder,
    output logic               busy,
    output logic               done,
    output logic [2*width-1:0] product
);

    localparam int unsigned CW = $clog2(width + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic               last_step;
    logic               neg_r;
    logic [width-1:0]   mag_q;
    // Upper half accumulates partial sums; lower half starts as the multiplier
    // magnitude and is shifted out one bit per step.
    logic [2*width-1:0] acc;
    logic [2*width-1:0] acc_neg;
    logic [width-1:0]   addend;
    logic [width:0]     sum;

`ifdef MULT_REM_SEQ_REM_EN
    logic               tc_r;
    logic [width-1:0]   rem_r;
    logic [2*width-1:0] rem_ext;
`else
    logic               unused_rem;
    assign unused_rem = ^remainder;
`endif

    // Magnitude of an operand; -2^(w-1) maps onto itself as an unsigned value.
    function automatic logic [width-1:0] mag_of(input logic tc, input logic [width-1:0] x);
        return (tc && x[width-1]) ? (~x + 1'b1) : x;
    endfunction

    assign last_step = (cnt == CW'(width - 1));
    assign addend    = acc[0] ? mag_q : '0;
    assign sum       = {1'b0, acc[2*width-1:width]} + {1'b0, addend};
    assign acc_neg   = ~acc + 1'b1;

`ifdef MULT_REM_SEQ_REM_EN
    assign rem_ext = {{width{tc_r & rem_r[width-1]}}, rem_r};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_step) state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, shift-add iteration and final sign/addend fix-up.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            neg_r   <= 1'b0;
            mag_q   <= '0;
            acc     <= '0;
            product <= '0;
`ifdef MULT_REM_SEQ_REM_EN
            tc_r    <= 1'b0;
            rem_r   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        neg_r <= tc_mode & (quotient[width-1] ^ divisor[width-1]);
                        mag_q <= mag_of(tc_mode, quotient);
                        acc   <= {{width{1'b0}}, mag_of(tc_mode, divisor)};
`ifdef MULT_REM_SEQ_REM_EN
                        tc_r  <= tc_mode;
                        rem_r <= remainder;
`endif
                    end
                end
                RUN: begin
                    acc <= {sum, acc[width-1:1]};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    cnt <= '0;
`ifdef MULT_REM_SEQ_REM_EN
                    product <= (neg_r ? acc_neg : acc) + rem_ext;
`else
                    product <= neg_r ? acc_neg : acc;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
